// File: rtl/nebula_vc_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nebula_vc_link_scheduler
// Purpose  : Shares one output link among NUM_VCS virtual channels. It keeps
//            one downstream-buffer credit counter per VC and grants at most
//            one flit per cycle, round-robin among VCs with a pending flit and
//            at least one credit. The grant path is purely combinational.
// Options  : `define NEBULA_VC_PKT_LOCK_EN enables wormhole packet locking.
//            Once a packet starts on a VC, the link stays with that VC until
//            its tail flit goes out.
// Revision : 1.0 - initial release
// ============================================================================
module nebula_vc_link_scheduler #(
   parameter int NUM_VCS      = 4,
   parameter int MAX_CREDITS  = 4,
   parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1),
   parameter int VC_IDX_W     = $clog2(NUM_VCS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_VCS-1:0]              vc_valid,
   input  logic [NUM_VCS-1:0]              vc_tail,
   output logic [NUM_VCS-1:0]              vc_grant,
   input  logic                            link_ready,
   output logic                            link_valid,
   output logic [VC_IDX_W-1:0]             link_vc,
   input  logic [NUM_VCS-1:0]              credit_return,
   output logic [NUM_VCS*CREDIT_WIDTH-1:0] credit_count,
   output logic                            err_credit_overflow
);

   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_CREDITS);
   localparam logic [VC_IDX_W-1:0]     LAST_VC    = VC_IDX_W'(NUM_VCS - 1);

   logic [NUM_VCS-1:0]  has_credit;
   logic [NUM_VCS-1:0]  lock_allow;
   logic [NUM_VCS-1:0]  eligible;
   logic [NUM_VCS-1:0]  overflow_hit;
   logic [VC_IDX_W-1:0] rr_ptr;
   logic [VC_IDX_W-1:0] grant_idx;
   logic [VC_IDX_W-1:0] cand;
   logic                grant_found;

   assign eligible = vc_valid & has_credit & lock_allow & {NUM_VCS{link_ready}};

   // Round-robin search: the first eligible VC at or after rr_ptr, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < NUM_VCS; i++) begin
         cand = VC_IDX_W'((int'(rr_ptr) + i) % NUM_VCS);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Link-side outputs. They are forced idle while reset is held, even though
   // the registered state already resets asynchronously.
   always_comb begin
      vc_grant   = '0;
      link_valid = 1'b0;
      link_vc    = '0;
      if (grant_found && rst_n) begin
         vc_grant   = NUM_VCS'(1) << grant_idx;
         link_valid = 1'b1;
         link_vc    = grant_idx;
      end
   end

   // Pointer moves to just past the winner. It holds when no flit is sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (link_valid) begin
         rr_ptr <= (grant_idx == LAST_VC) ? '0 : grant_idx + VC_IDX_W'(1);
      end
   end

   // One independent credit counter per VC.
   for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
      logic [CREDIT_WIDTH-1:0] credit_q;
      logic                    at_max;

      assign at_max          = (credit_q == CREDIT_MAX);
      assign has_credit[v]   = (credit_q != '0);
      // A lone return to a full counter has nowhere to go. A return that
      // coincides with a grant just cancels out.
      assign overflow_hit[v] = credit_return[v] & ~vc_grant[v] & at_max;
      assign credit_count[v*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q;

      // A grant consumes a slot and a return frees one. Returns saturate at
      // the downstream depth.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            credit_q <= CREDIT_MAX;
         end else if (vc_grant[v] && !credit_return[v]) begin
            credit_q <= credit_q - CREDIT_WIDTH'(1);
         end else if (credit_return[v] && !vc_grant[v] && !at_max) begin
            credit_q <= credit_q + CREDIT_WIDTH'(1);
         end
      end
   end

   // Sticky protocol-error flag. Only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_credit_overflow <= 1'b0;
      end else if (|overflow_hit) begin
         err_credit_overflow <= 1'b1;
      end
   end

`ifdef NEBULA_VC_PKT_LOCK_EN
   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   logic [0:0]          lock_state;
   logic [0:0]          lock_state_nxt;
   logic [VC_IDX_W-1:0] lock_vc;
   logic [VC_IDX_W-1:0] lock_vc_nxt;

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= ST_UNLOCKED;
         lock_vc    <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_vc    <= lock_vc_nxt;
      end
   end

   // Lock next-state logic. A packet head that is not also its tail takes the
   // link, and the tail flit releases it.
   always_comb begin
      lock_state_nxt = lock_state;
      lock_vc_nxt    = lock_vc;
      case (lock_state)
         ST_UNLOCKED: begin
            if (link_valid && !vc_tail[grant_idx]) begin
               lock_state_nxt = ST_LOCKED;
               lock_vc_nxt    = grant_idx;
            end
         end
         ST_LOCKED: begin
            if (link_valid && vc_tail[lock_vc]) begin
               lock_state_nxt = ST_UNLOCKED;
            end
         end
         default: lock_state_nxt = ST_UNLOCKED;
      endcase
   end

   // Lock output. While locked, only the owning VC may compete. If it stalls,
   // the link idles.
   always_comb begin
      lock_allow = '1;
      if (lock_state == ST_LOCKED) begin
         lock_allow = NUM_VCS'(1) << lock_vc;
      end
   end
`else
   // Without locking, flits from different VCs interleave freely and the tail
   // markers play no part.
   logic unused_tail;
   assign lock_allow  = '1;
   assign unused_tail = ^vc_tail;
`endif

endmodule
`default_nettype wire
